// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle: pipeline register outputs in, writeback result,
// bypassed decode read data and debug capture out.
interface wb_regfile_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
);
    logic              valid_in;
    logic [XLEN-1:0]   ReadData_in;
    logic [XLEN-1:0]   ALUResult_in;
    logic [XLEN-1:0]   PC_plus4_in;
    logic [4:0]        rd_in;
    logic              RegWrite_in;
    logic [1:0]        ResultSrc_in;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   Result_out;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [CNT_W-1:0]  instret;
    logic [4:0]        last_wb_rd;
    logic [XLEN-1:0]   last_wb_data;

    modport slave (
        input  valid_in, ReadData_in, ALUResult_in, PC_plus4_in, rd_in,
               RegWrite_in, ResultSrc_in, rs1_addr, rs2_addr,
        output Result_out, rs1_data, rs2_data, instret, last_wb_rd, last_wb_data
    );

    modport master (
        output valid_in, ReadData_in, ALUResult_in, PC_plus4_in, rd_in,
               RegWrite_in, ResultSrc_in, rs1_addr, rs2_addr,
        input  Result_out, rs1_data, rs2_data, instret, last_wb_rd, last_wb_data
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: result select, 32x32 integer register file with
// same-cycle write-to-read bypass, retired-instruction counter and debug capture.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic           clk,
    input  logic           reset_n,
    wb_regfile_if.slave    bus
);

    typedef enum logic [1:0] {
        SRC_ALU  = 2'b00,
        SRC_MEM  = 2'b01,
        SRC_PC4  = 2'b10,
        SRC_ZERO = 2'b11
    } result_src_e;

    logic [XLEN-1:0]  regs_q [32];
    logic [CNT_W-1:0] instret_q, instret_d;
    logic [4:0]       last_wb_rd_q, last_wb_rd_d;
    logic [XLEN-1:0]  last_wb_data_q, last_wb_data_d;
    logic [XLEN-1:0]  result;
    logic             we;

    always_comb begin
        result = '0;
        unique case (result_src_e'(bus.ResultSrc_in))
            SRC_ALU:  result = bus.ALUResult_in;
            SRC_MEM:  result = bus.ReadData_in;
            SRC_PC4:  result = bus.PC_plus4_in;
            SRC_ZERO: result = '0;
        endcase
    end

    // Reset gates the commit so bypass is also off while reset_n is low.
    assign we = bus.valid_in & bus.RegWrite_in & (bus.rd_in != 5'd0) & reset_n;

    always_comb begin
        bus.rs1_data = regs_q[bus.rs1_addr];
        if (bus.rs1_addr == 5'd0)
            bus.rs1_data = '0;
        else if (we && (bus.rs1_addr == bus.rd_in))
            bus.rs1_data = result;

        bus.rs2_data = regs_q[bus.rs2_addr];
        if (bus.rs2_addr == 5'd0)
            bus.rs2_data = '0;
        else if (we && (bus.rs2_addr == bus.rd_in))
            bus.rs2_data = result;
    end

    always_comb begin
        instret_d      = instret_q + CNT_W'(bus.valid_in);
        last_wb_rd_d   = last_wb_rd_q;
        last_wb_data_d = last_wb_data_q;
        if (we) begin
            last_wb_rd_d   = bus.rd_in;
            last_wb_data_d = result;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: the register array is reset explicitly because software may
            // read any register after reset and expects zero, not X.
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
            instret_q      <= '0;
            last_wb_rd_q   <= '0;
            last_wb_data_q <= '0;
        end else begin
            if (we) regs_q[bus.rd_in] <= result;
            instret_q      <= instret_d;
            last_wb_rd_q   <= last_wb_rd_d;
            last_wb_data_q <= last_wb_data_d;
        end
    end

    assign bus.Result_out   = result;
    assign bus.instret      = instret_q;
    assign bus.last_wb_rd   = last_wb_rd_q;
    assign bus.last_wb_data = last_wb_data_q;

endmodule
